// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter: one-word holding buffer feeding a framed
// synchronous serial link (divided sclk, data, active-low frame select).
module serializer_tx #(
    parameter int DATA_WIDTH = 12,
    parameter int CLK_DIV    = 10,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_HALVES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_sclk,
    output logic                  o_sdata,
    output logic                  o_cs_n,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int H  = CLK_DIV / 2;
    localparam int HW = (H > 1) ? $clog2(H) : 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int GW = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

    localparam logic [HW-1:0] HALF_LAST = HW'(H - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_HALVES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]            state_reg, state_next;
    logic [HW-1:0]         half_reg, half_next;
    logic [BW-1:0]         bit_reg, bit_next;
    logic [GW-1:0]         gap_reg, gap_next;
    logic                  phase_reg, phase_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] buf_reg, buf_next;
    logic                  buf_full_reg, buf_full_next;
    logic                  sclk_reg, sclk_next;
    logic                  sdata_reg, sdata_next;
    logic                  cs_n_reg, cs_n_next;
    logic                  done_reg, done_next;
    logic                  take_buf;
    logic                  half_end;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    // Bit that becomes current after one shift of w.
    function automatic logic second_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-2] : w[1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shifted(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    assign half_end = (half_reg == HALF_LAST);

    always_comb begin
        state_next    = state_reg;
        half_next     = half_reg;
        bit_next      = bit_reg;
        gap_next      = gap_reg;
        phase_next    = phase_reg;
        shift_next    = shift_reg;
        buf_next      = buf_reg;
        buf_full_next = buf_full_reg;
        sclk_next     = sclk_reg;
        sdata_next    = sdata_reg;
        cs_n_next     = cs_n_reg;
        done_next     = 1'b0;
        take_buf      = 1'b0;

        if (state_reg != ST_IDLE) begin
            half_next = half_end ? '0 : half_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (buf_full_reg) begin
                    take_buf   = 1'b1;
                    state_next = ST_LEAD;
                    half_next  = '0;
                    shift_next = buf_reg;
                    sdata_next = first_bit(buf_reg);
                    cs_n_next  = 1'b0;
                    sclk_next  = 1'b0;
                end
            end
            ST_LEAD: begin
                if (half_end) begin
                    state_next = ST_SHIFT;
                    phase_next = 1'b1;
                    bit_next   = '0;
                    sclk_next  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (half_end && phase_reg) begin
                    phase_next = 1'b0;
                    sclk_next  = 1'b0;
                    shift_next = shifted(shift_reg);
                    // A queued word presents its first bit a full half period before the next rising sclk.
                    if (bit_reg == BIT_LAST && buf_full_reg) begin
                        sdata_next = first_bit(buf_reg);
                    end else begin
                        sdata_next = second_bit(shift_reg);
                    end
                end else if (half_end && bit_reg != BIT_LAST) begin
                    phase_next = 1'b1;
                    sclk_next  = 1'b1;
                    bit_next   = bit_reg + 1'b1;
                end else if (half_end) begin
                    done_next = 1'b1;
                    if (buf_full_reg) begin
                        take_buf   = 1'b1;
                        shift_next = buf_reg;
                        sdata_next = first_bit(buf_reg);
                        bit_next   = '0;
                        phase_next = 1'b1;
                        sclk_next  = 1'b1;
                    end else begin
                        state_next = ST_GAP;
                        cs_n_next  = 1'b1;
                        sdata_next = 1'b0;
                        gap_next   = '0;
                    end
                end
            end
            ST_GAP: begin
                if (half_end) begin
                    if (gap_reg == GAP_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        gap_next = gap_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Buffer can only be emptied while full, so a load never coincides with a handshake.
        if (take_buf) begin
            buf_full_next = 1'b0;
        end else if (i_valid && !buf_full_reg) begin
            buf_full_next = 1'b1;
            buf_next      = i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            half_reg     <= '0;
            bit_reg      <= '0;
            gap_reg      <= '0;
            phase_reg    <= 1'b0;
            shift_reg    <= '0;
            buf_reg      <= '0;
            buf_full_reg <= 1'b0;
            sclk_reg     <= 1'b0;
            sdata_reg    <= 1'b0;
            cs_n_reg     <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            half_reg     <= half_next;
            bit_reg      <= bit_next;
            gap_reg      <= gap_next;
            phase_reg    <= phase_next;
            shift_reg    <= shift_next;
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            sclk_reg     <= sclk_next;
            sdata_reg    <= sdata_next;
            cs_n_reg     <= cs_n_next;
            done_reg     <= done_next;
        end
    end

    assign o_ready = ~buf_full_reg;
    assign o_busy  = (state_reg != ST_IDLE) | buf_full_reg;
    assign o_sclk  = sclk_reg;
    assign o_sdata = sdata_reg;
    assign o_cs_n  = cs_n_reg;
    assign o_done  = done_reg;

endmodule

// File: tb/tb_serializer_tx.sv
// Bench for serializer_tx: two instances (12-bit MSB-first div 4, 8-bit LSB-first div 10)
// with bus monitors decoding frames against a queue of expected words and frame lengths.
module tb_serializer_tx;
    localparam int AW = 12;
    localparam int AH = 2;
    localparam int BW = 8;
    localparam int BH = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [AW-1:0] data_a = '0;
    logic          valid_a = 1'b0;
    logic          ready_a, sclk_a, sdata_a, cs_a, busy_a, done_a;
    logic [BW-1:0] data_b = '0;
    logic          valid_b = 1'b0;
    logic          ready_b, sclk_b, sdata_b, cs_b, busy_b, done_b;

    logic [AW-1:0] exp_a[$];
    logic [BW-1:0] exp_b[$];
    int            exp_len_a[$];
    int            exp_len_b[$];
    int            bits_a = 0, edges_a = 0, dones_a = 0;
    int            bits_b = 0, edges_b = 0, dones_b = 0;

    always #5 clk = ~clk;

    serializer_tx #(.DATA_WIDTH(AW), .CLK_DIV(2*AH), .MSB_FIRST(1'b1), .GAP_HALVES(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data_a), .i_valid(valid_a), .o_ready(ready_a),
        .o_sclk(sclk_a), .o_sdata(sdata_a), .o_cs_n(cs_a), .o_busy(busy_a), .o_done(done_a)
    );

    serializer_tx #(.DATA_WIDTH(BW), .CLK_DIV(2*BH), .MSB_FIRST(1'b0), .GAP_HALVES(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data_b), .i_valid(valid_b), .o_ready(ready_b),
        .o_sclk(sclk_b), .o_sdata(sdata_b), .o_cs_n(cs_b), .o_busy(busy_b), .o_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor A: 12-bit MSB-first, half period 2.
    logic [AW-1:0] word_a = '0;
    int  low_a = 0, hi_a = 0, hics_a = 0, cslen_a = 0;
    bit  psclk_a = 0, psdata_a = 0, pcs_a = 1, pdone_a = 0, seen_a = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                word_a = '0; bits_a = 0; low_a = 0; hi_a = 0; hics_a = 0; cslen_a = 0;
                psclk_a = 0; psdata_a = 0; pcs_a = 1; pdone_a = 0; seen_a = 0;
            end else begin
                if (!cs_a && pcs_a) begin
                    if (seen_a) check("a_gap_min", hics_a >= 2*AH, 1);
                    cslen_a = 0;
                end
                if (cs_a && !pcs_a) begin
                    check("a_len_expected", exp_len_a.size() > 0, 1);
                    if (exp_len_a.size() > 0) check("a_cs_low_len", cslen_a, exp_len_a.pop_front());
                    seen_a = 1;
                    hics_a = 0;
                end
                if (cs_a) hics_a++; else cslen_a++;
                if (sclk_a && !psclk_a) begin
                    edges_a++;
                    check("a_sclk_low", low_a, AH);
                    check("a_cs_at_sclk", cs_a, 0);
                    check("a_sdata_setup", sdata_a, psdata_a);
                    low_a = 0;
                    hi_a = 1;
                    word_a = {word_a[AW-2:0], sdata_a};
                    bits_a++;
                    if (bits_a == AW) begin
                        bits_a = 0;
                        check("a_word_expected", exp_a.size() > 0, 1);
                        if (exp_a.size() > 0) check("a_word", word_a, exp_a.pop_front());
                    end
                end else if (sclk_a) begin
                    hi_a++;
                end else begin
                    if (psclk_a) begin
                        check("a_sclk_high", hi_a, AH);
                        hi_a = 0;
                    end
                    low_a = cs_a ? 0 : low_a + 1;
                end
                if (done_a) begin
                    dones_a++;
                    check("a_done_single", pdone_a, 0);
                end
                psclk_a = sclk_a; psdata_a = sdata_a; pcs_a = cs_a; pdone_a = done_a;
            end
        end
    end

    // Monitor B: 8-bit LSB-first, half period 5.
    logic [BW-1:0] word_b = '0;
    int  low_b = 0, hi_b = 0, hics_b = 0, cslen_b = 0;
    bit  psclk_b = 0, psdata_b = 0, pcs_b = 1, pdone_b = 0, seen_b = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                word_b = '0; bits_b = 0; low_b = 0; hi_b = 0; hics_b = 0; cslen_b = 0;
                psclk_b = 0; psdata_b = 0; pcs_b = 1; pdone_b = 0; seen_b = 0;
            end else begin
                if (!cs_b && pcs_b) begin
                    if (seen_b) check("b_gap_min", hics_b >= 2*BH, 1);
                    cslen_b = 0;
                end
                if (cs_b && !pcs_b) begin
                    check("b_len_expected", exp_len_b.size() > 0, 1);
                    if (exp_len_b.size() > 0) check("b_cs_low_len", cslen_b, exp_len_b.pop_front());
                    seen_b = 1;
                    hics_b = 0;
                end
                if (cs_b) hics_b++; else cslen_b++;
                if (sclk_b && !psclk_b) begin
                    edges_b++;
                    check("b_sclk_low", low_b, BH);
                    check("b_cs_at_sclk", cs_b, 0);
                    check("b_sdata_setup", sdata_b, psdata_b);
                    low_b = 0;
                    hi_b = 1;
                    word_b = {sdata_b, word_b[BW-1:1]};
                    bits_b++;
                    if (bits_b == BW) begin
                        bits_b = 0;
                        check("b_word_expected", exp_b.size() > 0, 1);
                        if (exp_b.size() > 0) check("b_word", word_b, exp_b.pop_front());
                    end
                end else if (sclk_b) begin
                    hi_b++;
                end else begin
                    if (psclk_b) begin
                        check("b_sclk_high", hi_b, BH);
                        hi_b = 0;
                    end
                    low_b = cs_b ? 0 : low_b + 1;
                end
                if (done_b) begin
                    dones_b++;
                    check("b_done_single", pdone_b, 0);
                end
                psclk_b = sclk_b; psdata_b = sdata_b; pcs_b = cs_b; pdone_b = done_b;
            end
        end
    end

    // Drives one word and returns #1 after the accepting edge; keep leaves i_valid asserted.
    task automatic send(input int lane, input logic [31:0] w, input bit keep);
        bit hs;
        int n;
        n = 0;
        if (lane == 0) begin data_a = w[AW-1:0]; valid_a = 1'b1; end
        else begin data_b = w[BW-1:0]; valid_b = 1'b1; end
        do begin
            hs = (lane == 0) ? ready_a : ready_b;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 1000);
        check("handshake_timeout", hs, 1);
        if (hs) begin
            if (lane == 0) exp_a.push_back(w[AW-1:0]);
            else exp_b.push_back(w[BW-1:0]);
        end
        if (!keep) begin
            if (lane == 0) valid_a = 1'b0; else valid_b = 1'b0;
        end
    endtask

    task automatic wait_idle(input int lane);
        bit ok;
        ok = 0;
        for (int n = 0; n < 3000 && !ok; n++) begin
            @(posedge clk);
            #1;
            ok = (lane == 0) ? (!busy_a && cs_a) : (!busy_b && cs_b);
        end
        check("idle_timeout", ok, 1);
    endtask

    task automatic wait_done_a(output int t);
        bit ok;
        ok = 0;
        t = 0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(posedge clk);
            #1;
            ok = done_a;
        end
        t = cyc;
        check("done_timeout", ok, 1);
    endtask

    task automatic wait_bits_a(input int target);
        bit ok;
        ok = 0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(posedge clk);
            #1;
            ok = (bits_a == target);
        end
        check("bits_timeout", ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, d0, t1, t2;
        logic [AW-1:0] fifo[$];

        repeat (3) @(posedge clk);
        #1;
        check("a_reset_outputs", {ready_a, sclk_a, sdata_a, cs_a, busy_a, done_a}, 6'b100100);
        check("b_reset_outputs", {ready_b, sclk_b, sdata_b, cs_b, busy_b, done_b}, 6'b100100);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single word, MSB first
        e0 = edges_a; d0 = dones_a;
        exp_len_a.push_back(50);
        send(0, 32'hA5C, 1'b0);
        check("a_ready_drop", ready_a, 0);
        check("a_cs_before_fall", cs_a, 1);
        @(posedge clk);
        #1;
        check("a_cs_fall_latency", cs_a, 0);
        check("a_ready_after_load", ready_a, 1);
        wait_idle(0);
        check("a_single_edges", edges_a - e0, 12);
        check("a_single_dones", dones_a - d0, 1);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back: second word accepted during bit 3
        e0 = edges_a; d0 = dones_a;
        exp_len_a.push_back(98);
        send(0, 32'hFFF, 1'b0);
        wait_bits_a(4);
        send(0, 32'h000, 1'b0);
        wait_done_a(t1);
        check("a_ready_after_reload", ready_a, 1);
        check("a_busy_chained", busy_a, 1);
        check("a_cs_chained", cs_a, 0);
        wait_done_a(t2);
        check("a_done_spacing", t2 - t1, 48);
        wait_idle(0);
        check("a_b2b_edges", edges_a - e0, 24);
        check("a_b2b_dones", dones_a - d0, 2);

        // Backpressure: valid held high across three queued words
        e0 = edges_a; d0 = dones_a;
        fifo.push_back(12'h3C1);
        fifo.push_back(12'h0F0);
        fifo.push_back(12'hE07);
        exp_len_a.push_back(146);
        while (fifo.size() > 0) begin
            send(0, {20'd0, fifo.pop_front()}, 1'b1);
            check("a_ready_low_full", ready_a, 0);
        end
        valid_a = 1'b0;
        wait_idle(0);
        check("a_bp_edges", edges_a - e0, 36);
        check("a_bp_dones", dones_a - d0, 3);

        // Reset in mid-frame at bit 5
        exp_len_a.push_back(50);
        send(0, 32'h5A5, 1'b0);
        wait_bits_a(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("a_async_reset_outputs", {ready_a, sclk_a, sdata_a, cs_a, busy_a, done_a}, 6'b100100);
        exp_a.delete();
        exp_len_a.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("a_idle_after_reset", {ready_a, cs_a, busy_a}, 3'b110);
        e0 = edges_a;
        exp_len_a.push_back(50);
        send(0, 32'h123, 1'b0);
        wait_idle(0);
        check("a_post_reset_edges", edges_a - e0, 12);
        check("a_no_residual_bits", bits_a, 0);

        // LSB-first single bit and divider sweep on instance B
        e0 = edges_b; d0 = dones_b;
        exp_len_b.push_back(85);
        send(1, 32'h01, 1'b0);
        wait_idle(1);
        exp_len_b.push_back(85);
        send(1, 32'hC3, 1'b0);
        wait_idle(1);
        check("b_edges", edges_b - e0, 16);
        check("b_dones", dones_b - d0, 2);

        check("a_queue_drained", exp_a.size() + exp_len_a.size(), 0);
        check("b_queue_drained", exp_b.size() + exp_len_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
